// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce filter slice.
// FSM encoding and the registered output bundle.
package debounce_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    typedef struct packed {
        logic q;
        logic rise;
        logic fall;
        logic busy;
    } dbf_out_t;

endpackage

// File: rtl/debounce_filter_sync2.sv
// Two-flop synchronizer bringing the raw D level into the CK domain.
// Both stages reset to INIT so a reset never creates a false edge.
module sync2 #(
    parameter logic INIT = 1'b0
) (
    input  logic CK,
    input  logic CD,
    input  logic D,
    output logic Q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = D;
        s2_d = s1_q;
    end

    always_ff @(posedge CK) begin
        if (CD) begin
            s1_q <= INIT;
            s2_q <= INIT;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign Q = s2_q;

endmodule

// File: rtl/debounce_filter.sv
// Debounce filter: Q follows the synchronized input only after it has
// held a new level for STABLE EN-qualified cycles; edges pulse RISE/FALL.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int   STABLE = 4,
    parameter int   CNT_W  = 8,
    parameter logic INIT   = 1'b0
) (
    input  logic CK,
    input  logic CD,
    input  logic D,
    input  logic EN,
    output logic Q,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);

    logic             s2;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dbf_out_t         out_q, out_d;

    sync2 #(
        .INIT(INIT)
    ) u_sync (
        .CK(CK),
        .CD(CD),
        .D (D),
        .Q (s2)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_d.q    = out_q.q;
        out_d.rise = 1'b0;
        out_d.fall = 1'b0;
        if (state_q == IDLE) begin
            if (s2 != out_q.q) begin
                state_d = COUNT;
                cnt_d   = '0;
            end
        end else if (s2 == out_q.q) begin
            // input fell back before the window closed: reject the glitch
            state_d = IDLE;
            cnt_d   = '0;
        end else if (EN) begin
            if (cnt_q == LAST) begin
                out_d.q    = s2;
                out_d.rise = s2;
                out_d.fall = ~s2;
                state_d    = IDLE;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        out_d.busy = (state_d == COUNT);
    end

    always_ff @(posedge CK) begin
        if (CD) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '{q: INIT, rise: 1'b0, fall: 1'b0, busy: 1'b0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign Q    = out_q.q;
    assign RISE = out_q.rise;
    assign FALL = out_q.fall;
    assign BUSY = out_q.busy;

endmodule

// File: tb/tb_debounce_filter.sv
// Scoreboard bench: directed vectors for STABLE=4, reference model for STABLE=1.
module tb_debounce_filter;

    logic CK = 1'b0;
    logic CD = 1'b1;
    logic D  = 1'b0;
    logic EN = 1'b0;
    logic q0, r0, f0, b0;
    logic q1, r1, f1, b1;

    always #5 CK = ~CK;

    debounce_filter #(.STABLE(4), .CNT_W(8), .INIT(1'b0)) dut0 (
        .CK(CK), .CD(CD), .D(D), .EN(EN),
        .Q(q0), .RISE(r0), .FALL(f0), .BUSY(b0)
    );

    debounce_filter #(.STABLE(1), .CNT_W(8), .INIT(1'b0)) dut1 (
        .CK(CK), .CD(CD), .D(D), .EN(EN),
        .Q(q1), .RISE(r1), .FALL(f1), .BUSY(b1)
    );

    typedef struct {
        string      name;
        logic [3:0] exp;
    } exp_t;

    exp_t       sb0[$];
    logic [3:0] sb1[$];
    int         n_vec = 0;
    int         n_err = 0;

    // expected {Q,RISE,FALL,BUSY} after the edge that follows this drive
    task automatic vec(input string name, input logic d, input logic en,
                       input logic cd, input logic [3:0] e);
        exp_t x;
        @(negedge CK);
        D  = d;
        EN = en;
        CD = cd;
        x.name = name;
        x.exp  = e;
        sb0.push_back(x);
        @(posedge CK);
    endtask

    task automatic chk(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    always begin : mon0
        exp_t e;
        @(posedge CK);
        #1;
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            n_vec++;
            if ({q0, r0, f0, b0} !== e.exp) begin
                n_err++;
                $display("FAIL %s @%0t: qrfb got %b want %b",
                         e.name, $time, {q0, r0, f0, b0}, e.exp);
            end
        end
    end

    // cycle-accurate reference for the STABLE=1 instance
    localparam int S1 = 1;
    logic ms1 = 1'b0, ms2 = 1'b0, mq = 1'b0, mst = 1'b0;
    int   mcnt = 0;

    always @(posedge CK) begin : model1
        logic nr, nf, ns1, ns2;
        nr = 1'b0;
        nf = 1'b0;
        if (CD) begin
            ms1 = 1'b0; ms2 = 1'b0; mq = 1'b0;
            mst = 1'b0; mcnt = 0;
        end else begin
            ns1 = D;
            ns2 = ms1;
            if (!mst) begin
                if (ms2 != mq) begin
                    mst = 1'b1; mcnt = 0;
                end
            end else if (ms2 == mq) begin
                mst = 1'b0; mcnt = 0;
            end else if (EN) begin
                if (mcnt == S1 - 1) begin
                    nr = ms2; nf = ~ms2; mq = ms2;
                    mst = 1'b0; mcnt = 0;
                end else begin
                    mcnt++;
                end
            end
            ms1 = ns1;
            ms2 = ns2;
        end
        sb1.push_back({mq, nr, nf, mst});
    end

    always begin : mon1
        logic [3:0] e;
        @(posedge CK);
        #1;
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            n_vec++;
            if ({q1, r1, f1, b1} !== e) begin
                n_err++;
                $display("FAIL s1_model @%0t: qrfb got %b want %b",
                         $time, {q1, r1, f1, b1}, e);
            end
        end
    end

    logic [3:0] t_rise [8];
    logic [3:0] t_fall [8];
    logic [3:0] t_glit [8];
    logic [3:0] t_rst  [8];

    initial begin
        t_rise = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                   4'b0001, 4'b0001, 4'b1100, 4'b1000};
        t_fall = '{4'b1000, 4'b1000, 4'b1001, 4'b1001,
                   4'b1001, 4'b1001, 4'b0010, 4'b0000};
        t_glit = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                   4'b0001, 4'b0001, 4'b0000, 4'b0000};
        t_rst  = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                   4'b0001, 4'b0001, 4'b1100, 4'b1000};

        vec("reset", 1'b0, 1'b0, 1'b1, 4'b0000);
        vec("reset", 1'b0, 1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < 3; i++)
            vec("idle_nopulse", 1'b0, 1'b1, 1'b0, 4'b0000);

        for (int i = 0; i < 8; i++) begin
            vec("rise", 1'b1, 1'b1, 1'b0, t_rise[i]);
            if (i == 2) begin #1; chk("s1_lat_e3", q1, 1'b0); end
            if (i == 3) begin #1; chk("s1_lat_e4", q1, 1'b1); end
        end

        for (int i = 0; i < 8; i++)
            vec("fall", 1'b0, 1'b1, 1'b0, t_fall[i]);

        for (int i = 0; i < 8; i++)
            vec("glitch", (i < 4), 1'b1, 1'b0, t_glit[i]);

        for (int i = 1; i <= 16; i++)
            vec("en_tick", 1'b1, ((i % 3) == 0), 1'b0,
                (i <= 2)  ? 4'b0000 :
                (i <= 14) ? 4'b0001 :
                (i == 15) ? 4'b1100 : 4'b1000);
        for (int i = 0; i < 8; i++)
            vec("restore", 1'b0, 1'b1, 1'b0, t_fall[i]);

        for (int i = 0; i < 6; i++)
            vec("rst_pre", 1'b1, 1'b1, 1'b0, t_rise[i]);
        vec("rst_commit", 1'b1, 1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < 8; i++)
            vec("rst_after", 1'b1, 1'b1, 1'b0, t_rst[i]);

        for (int i = 0; i < 10000; i++) begin
            @(negedge CK);
            if ($urandom_range(3) == 0) D = ~D;
            EN = 1'($urandom_range(1));
            CD = ($urandom_range(199) == 0);
        end
        @(negedge CK);
        CD = 1'b0;
        repeat (3) @(negedge CK);

        n_vec++;
        if (sb0.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", sb0.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
